score_frame_builder: RTL and testbench

Converts the territory counts from the territory counter into the eight-character frame that the seven-segment driver (`display_alphaNumhex`) scans out. Each count is converted to decimal with a serial double-dabble, leading zeros are blanked, and the result is registered into the frame. After game over, the score frame alternates with a result banner. The block sits between `territory_counter` and `display_alphaNumhex` and replaces the combinational `seg_data` assignments in `top_level`.

---
 rtl/go_disp_pkg.sv | 42 ++++
 rtl/bcd_serial8.sv | 48 ++++
 rtl/score_frame_builder.sv | 199 +++++++++++++++++++
 tb/tb_score_frame_builder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/go_disp_pkg.sv
// Shared display definitions for the Go board seven-segment path: character codes,
// frame type, fixed banner frames and the BCD-to-character helper.
package go_disp_pkg;

  localparam int unsigned CODE_W = 6;

  typedef logic [CODE_W-1:0]      code_t;
  typedef logic [7:0][CODE_W-1:0] frame_t;   // index 7 is the leftmost digit
  typedef logic [2:0][CODE_W-1:0] digits_t;

  localparam code_t BLANK = code_t'(10);
  localparam code_t C     = code_t'(13);
  localparam code_t E     = code_t'(15);
  localparam code_t J     = code_t'(20);
  localparam code_t L     = code_t'(22);
  localparam code_t O     = code_t'(25);
  localparam code_t R     = code_t'(28);
  localparam code_t S     = code_t'(29);
  localparam code_t U     = code_t'(31);
  localparam code_t X     = code_t'(34);

  localparam frame_t LOSER_FRAME = {J, O, E, BLANK, S, U, X, BLANK};
  localparam frame_t COOL_FRAME  = {BLANK, BLANK, BLANK, BLANK, C, O, O, L};
  localparam frame_t ZERO_FRAME  = {BLANK, BLANK, code_t'(0), BLANK,
                                    BLANK, BLANK, BLANK, code_t'(0)};

  typedef enum logic [1:0] {StIdle, StShift, StCommit} conv_state_e;

  // Hundreds/tens/ones characters with leading zeros blanked; ones always shown.
  function automatic digits_t bcd_digits(logic [11:0] bcd);
    digits_t d;
    d[2] = (bcd[11:8] == 4'd0) ? BLANK : code_t'(bcd[11:8]);
    d[1] = (bcd[11:4] == 8'd0) ? BLANK : code_t'(bcd[7:4]);
    d[0] = code_t'(bcd[3:0]);
    return d;
  endfunction

  function automatic frame_t score_frame(logic [11:0] b_bcd, logic [11:0] w_bcd);
    return {bcd_digits(b_bcd), BLANK, BLANK, bcd_digits(w_bcd)};
  endfunction

endpackage

// File: rtl/bcd_serial8.sv
// Serial double-dabble for one 8-bit count: load, then eight steps yield three BCD digits.
module bcd_serial8 (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic        step_in,
  input  logic [7:0]  bin_in,
  output logic [11:0] bcd_out,
  output logic        done_out
);

  // Binary bits followed by a marker bit; after eight shifts only the marker remains at bit 8.
  logic [8:0]  sreg_q, sreg_d;
  logic [11:0] bcd_q, bcd_d;
  logic [10:0] adj;

  function automatic logic [3:0] nib_adj(logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    // Hundreds never reaches 5 before the last shift for inputs up to 255.
    adj    = {bcd_q[10:8], nib_adj(bcd_q[7:4]), nib_adj(bcd_q[3:0])};
    sreg_d = sreg_q;
    bcd_d  = bcd_q;
    if (load_in) begin
      sreg_d = {bin_in, 1'b1};
      bcd_d  = '0;
    end else if (step_in) begin
      bcd_d  = {adj, sreg_q[8]};
      sreg_d = {sreg_q[7:0], 1'b0};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sreg_q <= '0;
      bcd_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      bcd_q  <= bcd_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign done_out = sreg_q[8] && (sreg_q[7:0] == 8'd0);

endmodule

// File: rtl/score_frame_builder.sv
// Converts black/white territory counts into the registered eight-character display frame,
// alternating with a result banner while the game is over.
module score_frame_builder #(
  parameter int unsigned CODE_W       = 6,
  parameter int unsigned BLINK_CYCLES = 32_500_000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [7:0]             bcount_in,
  input  logic [7:0]             wcount_in,
  input  logic                   terr_ready_in,
  input  logic                   game_over_in,
  input  logic                   my_color_in,
  output logic [7:0][CODE_W-1:0] data_out,
  output logic                   busy_out,
  output logic                   valid_out
);

  import go_disp_pkg::*;

  localparam int unsigned       BlinkW    = $clog2(BLINK_CYCLES);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  conv_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_b_q, pend_b_d, pend_w_q, pend_w_d;
  logic [7:0]        cur_b_q, cur_b_d, cur_w_q, cur_w_d;
  logic [7:0]        last_b_q, last_b_d, last_w_q, last_w_d;
  frame_t            score_q, score_d, data_q, data_d, banner;
  logic              busy_q, busy_d, valid_q, valid_d;
  logic [BlinkW-1:0] blink_q, blink_d, blink_eff;
  logic              banner_q, banner_d, banner_eff, go_q, go_rise;
  logic              load, step;
  logic [7:0]        load_b, load_w, mine, opp;
  logic [11:0]       b_bcd, w_bcd;
  logic              b_done, w_done;

  bcd_serial8 u_bcd_black (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_in  (load),
    .step_in  (step),
    .bin_in   (load_b),
    .bcd_out  (b_bcd),
    .done_out (b_done)
  );

  bcd_serial8 u_bcd_white (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_in  (load),
    .step_in  (step),
    .bin_in   (load_w),
    .bcd_out  (w_bcd),
    .done_out (w_done)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      pend_b_q <= '0;
      pend_w_q <= '0;
      cur_b_q  <= '0;
      cur_w_q  <= '0;
      last_b_q <= '0;
      last_w_q <= '0;
      score_q  <= ZERO_FRAME;
      data_q   <= ZERO_FRAME;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_b_q <= pend_b_d;
      pend_w_q <= pend_w_d;
      cur_b_q  <= cur_b_d;
      cur_w_q  <= cur_w_d;
      last_b_q <= last_b_d;
      last_w_q <= last_w_d;
      score_q  <= score_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_b_d = pend_b_q;
    pend_w_d = pend_w_q;
    cur_b_d  = cur_b_q;
    cur_w_d  = cur_w_q;
    load     = 1'b0;
    load_b   = bcount_in;
    load_w   = wcount_in;
    unique case (state_q)
      StIdle: begin
        if (terr_ready_in) begin
          load    = 1'b1;
          cnt_d   = 4'd8;
          state_d = StShift;
        end
      end
      StShift: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
        // A pulse in this very cycle is newer than anything pending, so it wins.
        if (terr_ready_in || pend_q) begin
          load    = 1'b1;
          cnt_d   = 4'd8;
          pend_d  = 1'b0;
          state_d = StShift;
          if (!terr_ready_in) begin
            load_b = pend_b_q;
            load_w = pend_w_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q == StShift && terr_ready_in) begin
      pend_d   = 1'b1;
      pend_b_d = bcount_in;
      pend_w_d = wcount_in;
    end
    if (load) begin
      cur_b_d = load_b;
      cur_w_d = load_w;
    end
  end

  assign step = (state_q == StShift);

  always_comb begin
    score_d  = score_q;
    last_b_d = last_b_q;
    last_w_d = last_w_q;
    valid_d  = (state_q == StCommit);
    busy_d   = (state_d != StIdle) || (state_q == StCommit);
    if (state_q == StCommit) begin
      score_d  = score_frame(b_bcd, w_bcd);
      last_b_d = cur_b_q;
      last_w_d = cur_w_q;
    end
  end

  // The rising-edge cycle acts as count 0 of the first banner half-period.
  assign go_rise    = game_over_in && !go_q;
  assign blink_eff  = go_rise ? '0 : blink_q;
  assign banner_eff = go_rise || banner_q;

  always_comb begin
    blink_d  = '0;
    banner_d = 1'b0;
    if (game_over_in) begin
      banner_d = banner_eff;
      blink_d  = blink_eff + 1'b1;
      if (blink_eff == BlinkLast) begin
        blink_d  = '0;
        banner_d = !banner_eff;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      blink_q  <= '0;
      banner_q <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      blink_q  <= blink_d;
      banner_q <= banner_d;
      go_q     <= game_over_in;
    end
  end

  assign mine   = my_color_in ? last_w_q : last_b_q;
  assign opp    = my_color_in ? last_b_q : last_w_q;
  assign banner = (mine < opp) ? LOSER_FRAME : COOL_FRAME;
  assign data_d = (game_over_in && banner_eff) ? banner : score_q;

  assign data_out  = data_q;
  assign busy_out  = busy_q;
  assign valid_out = valid_q;

  // The shared shift counter and the per-digit-path markers must agree at commit.
  conv_done_chk: assert property (@(posedge clk_in) disable iff (!rst_in)
    (state_q == StCommit) |-> (b_done && w_done));

endmodule

// File: tb/tb_score_frame_builder.sv
// Directed and randomized checks of score_frame_builder against an arithmetic reference model.
module tb_score_frame_builder;

  localparam int unsigned Blink = 4;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [7:0]               bcount_in, wcount_in;
  logic                     terr_ready_in, game_over_in, my_color_in;
  go_disp_pkg::frame_t      data_out;
  logic                     busy_out, valid_out;

  int npass  = 0;
  int ntotal = 0;

  score_frame_builder #(
    .CODE_W       (6),
    .BLINK_CYCLES (Blink)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bcount_in     (bcount_in),
    .wcount_in     (wcount_in),
    .terr_ready_in (terr_ready_in),
    .game_over_in  (game_over_in),
    .my_color_in   (my_color_in),
    .data_out      (data_out),
    .busy_out      (busy_out),
    .valid_out     (valid_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: decimal digits by division, leading zeros blanked (code 10).
  function automatic logic [17:0] ref_trio(int v);
    int h, t, o;
    logic [5:0] ch, ct, co;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    ch = (h == 0) ? 6'd10 : 6'(h);
    ct = (h == 0 && t == 0) ? 6'd10 : 6'(t);
    co = 6'(o);
    return {ch, ct, co};
  endfunction

  function automatic go_disp_pkg::frame_t ref_frame(int b, int w);
    return {ref_trio(b), 6'd10, 6'd10, ref_trio(w)};
  endfunction

  function automatic go_disp_pkg::frame_t ref_banner(int b, int w, logic white);
    int mine, opp;
    mine = white ? w : b;
    opp  = white ? b : w;
    if (mine < opp) return {6'd20, 6'd25, 6'd15, 6'd10, 6'd29, 6'd31, 6'd34, 6'd10};
    return {6'd10, 6'd10, 6'd10, 6'd10, 6'd13, 6'd25, 6'd25, 6'd22};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_frame(input string tag, input go_disp_pkg::frame_t obs,
                             input go_disp_pkg::frame_t exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // Pulse the counts from idle; expects valid 10 edges after raising the pulse.
  task automatic convert(input int b, input int w, input string tag);
    int n;
    bcount_in     = 8'(b);
    wcount_in     = 8'(w);
    terr_ready_in = 1'b1;
    tick();
    terr_ready_in = 1'b0;
    n = 1;
    check_bit({tag, "_busy_hi"}, busy_out, 1'b1);
    while (!valid_out && n < 30) begin
      tick();
      n++;
    end
    check_int({tag, "_latency"}, n, 10);
    tick();
    check_frame({tag, "_frame"}, data_out, ref_frame(b, w));
    check_bit({tag, "_busy_lo"}, busy_out, 1'b0);
  endtask

  // Raise game over and compare 2*Blink cycles of banner/score alternation.
  task automatic check_blink(input int b, input int w, input logic white, input string tag);
    go_disp_pkg::frame_t exp;
    my_color_in  = white;
    game_over_in = 1'b1;
    for (int k = 0; k < 2 * Blink; k++) begin
      tick();
      exp = (((k / Blink) % 2) == 0) ? ref_banner(b, w, white) : ref_frame(b, w);
      check_frame($sformatf("%s_k%0d", tag, k), data_out, exp);
    end
    game_over_in = 1'b0;
    tick();
    check_frame({tag, "_off"}, data_out, ref_frame(b, w));
  endtask

  initial begin
    int nvalid, rb, rw;
    rst_in        = 1'b0;
    bcount_in     = '0;
    wcount_in     = '0;
    terr_ready_in = 1'b0;
    game_over_in  = 1'b0;
    my_color_in   = 1'b0;

    repeat (3) tick();
    check_frame("rst_frame", data_out, ref_frame(0, 0));
    check_bit("rst_busy", busy_out, 1'b0);
    check_bit("rst_valid", valid_out, 1'b0);
    rst_in = 1'b1;
    repeat (3) tick();
    check_frame("idle_frame", data_out, ref_frame(0, 0));
    check_bit("idle_busy", busy_out, 1'b0);

    convert(81, 7, "c81_7");
    convert(255, 100, "c255_100");
    convert(0, 0, "c0_0");

    // Closely spaced pulses: the middle one is overwritten before it starts.
    bcount_in = 8'd5; wcount_in = 8'd5; terr_ready_in = 1'b1;
    tick();
    terr_ready_in = 1'b0;
    repeat (2) tick();
    bcount_in = 8'd9; wcount_in = 8'd9; terr_ready_in = 1'b1;
    tick();
    terr_ready_in = 1'b0;
    tick();
    bcount_in = 8'd12; wcount_in = 8'd3; terr_ready_in = 1'b1;
    tick();
    terr_ready_in = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid_out) nvalid++;
      tick();
    end
    check_int("chain_valid_count", nvalid, 2);
    check_frame("chain_frame", data_out, ref_frame(12, 3));
    check_bit("chain_busy", busy_out, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rb = int'($urandom_range(0, 255));
      rw = int'($urandom_range(0, 255));
      convert(rb, rw, $sformatf("rand%0d", i));
    end

    convert(30, 40, "c30_40");
    check_blink(30, 40, 1'b0, "blink_black");
    check_blink(30, 40, 1'b1, "blink_white");
    convert(40, 40, "c40_40");
    check_blink(40, 40, 1'b0, "blink_tie");

    for (int i = 0; i < 3; i++) begin
      rb = int'($urandom_range(0, 255));
      rw = (i == 2) ? rb : int'($urandom_range(0, 255));
      convert(rb, rw, $sformatf("gorand%0d", i));
      check_blink(rb, rw, 1'($urandom_range(0, 1)), $sformatf("gorand%0d_blink", i));
    end

    // Asynchronous reset part-way through a conversion.
    convert(200, 13, "pre_rst");
    bcount_in = 8'd81; wcount_in = 8'd7; terr_ready_in = 1'b1;
    tick();
    terr_ready_in = 1'b0;
    repeat (4) tick();
    #2 rst_in = 1'b0;
    #1;
    check_frame("async_rst_frame", data_out, ref_frame(0, 0));
    check_bit("async_rst_busy", busy_out, 1'b0);
    check_bit("async_rst_valid", valid_out, 1'b0);
    tick();
    rst_in = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_out) nvalid++;
    end
    check_int("post_rst_valid_count", nvalid, 0);
    check_frame("post_rst_frame", data_out, ref_frame(0, 0));
    check_bit("post_rst_busy", busy_out, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
